// File: rtl/i8008_timing_ctrl.sv
// rtl/i8008_timing_ctrl.sv - 8008 state sequencer: S/SYNC status, machine-cycle index, step strobes,
// READY waits, HLT stop and interrupt acceptance at instruction boundaries.
module i8008_timing_ctrl #(
  parameter int CLKS_PER_STATE = 2,
  parameter int MAX_CYC        = 3
) (
  input  logic       CLK1,
  input  logic       nRST,
  input  logic       READY,
  input  logic       INT,
  input  logic [1:0] CYC_LEN,
  input  logic       LAST_CYC,
  input  logic       HALT,
  output logic [2:0] S,
  output logic       SYNC,
  output logic [1:0] CYC,
  output logic       STEP,
  output logic       INTACK,
  output logic       IRQ_PEND
);

  localparam int CW = (CLKS_PER_STATE > 2) ? $clog2(CLKS_PER_STATE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_STATE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_STATE / 2);
  localparam logic [1:0]    CYC_LAST = 2'(MAX_CYC - 1);

  typedef enum logic [2:0] {
    ST_T1   = 3'b010,
    ST_T1I  = 3'b011,
    ST_T2   = 3'b001,
    ST_WAIT = 3'b000,
    ST_T3   = 3'b100,
    ST_STOP = 3'b110,
    ST_T4   = 3'b111,
    ST_T5   = 3'b101
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    cyc_q;
  logic [1:0]    len_q;
  logic          intack_q;
  logic          irq_q;

  logic          step;
  logic          boundary_d;
  logic          eoc_irq_d;
  state_e        eoc_state_d;
  logic [1:0]    eoc_cyc_d;

  assign step = (cnt_q == CNT_LAST);

  // Outcome of an end-of-cycle, shared by the T3, T4 and T5 exits.
  always_comb begin
    boundary_d  = LAST_CYC || (cyc_q == CYC_LAST);
    eoc_irq_d   = boundary_d && irq_q;
    eoc_state_d = eoc_irq_d ? ST_T1I : ST_T1;
    eoc_cyc_d   = boundary_d ? 2'd0 : cyc_q + 2'd1;
  end

  always_ff @(posedge CLK1) begin
    if (!nRST) begin
      state_q  <= ST_STOP;
      cnt_q    <= '0;
      cyc_q    <= 2'd0;
      len_q    <= 2'd0;
      intack_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q <= step ? '0 : cnt_q + CW'(1);
      if (INT) irq_q <= 1'b1;
      // Later assignments in this branch override the INT set: clearing wins.
      if (step) begin
        case (state_q)
          ST_T1, ST_T1I: state_q <= ST_T2;
          ST_T2, ST_WAIT: state_q <= READY ? ST_T3 : ST_WAIT;
          ST_T3: begin
            len_q <= CYC_LEN;
            if (cyc_q == 2'd0 && HALT) begin
              state_q  <= ST_STOP;
              intack_q <= 1'b0;
            end else if (CYC_LEN == 2'd0) begin
              state_q  <= eoc_state_d;
              cyc_q    <= eoc_cyc_d;
              intack_q <= eoc_irq_d;
              if (eoc_irq_d) irq_q <= 1'b0;
            end else begin
              state_q <= ST_T4;
            end
          end
          ST_T4: begin
            if (len_q == 2'd1) begin
              state_q  <= eoc_state_d;
              cyc_q    <= eoc_cyc_d;
              intack_q <= eoc_irq_d;
              if (eoc_irq_d) irq_q <= 1'b0;
            end else begin
              state_q <= ST_T5;
            end
          end
          ST_T5: begin
            state_q  <= eoc_state_d;
            cyc_q    <= eoc_cyc_d;
            intack_q <= eoc_irq_d;
            if (eoc_irq_d) irq_q <= 1'b0;
          end
          ST_STOP: begin
            if (irq_q) begin
              state_q  <= ST_T1I;
              cyc_q    <= 2'd0;
              intack_q <= 1'b1;
              irq_q    <= 1'b0;
            end
          end
          default: state_q <= ST_STOP;
        endcase
      end
    end
  end

  assign S        = state_q;
  assign SYNC     = (cnt_q < CNT_HALF);
  assign STEP     = step;
  assign CYC      = cyc_q;
  assign INTACK   = intack_q;
  assign IRQ_PEND = irq_q;

endmodule

// File: tb/tb_i8008_timing_ctrl.sv
// tb/tb_i8008_timing_ctrl.sv - vector table, corner sequences and random stimulus against a state-level model.
module tb_i8008_timing_ctrl;

  localparam int CLKS = 2;
  localparam int MAXC = 3;

  localparam logic [2:0] C_T1 = 3'b010, C_T1I = 3'b011, C_T2 = 3'b001, C_WAIT = 3'b000;
  localparam logic [2:0] C_T3 = 3'b100, C_STOP = 3'b110, C_T4 = 3'b111, C_T5 = 3'b101;

  logic       CLK1 = 1'b0;
  logic       nRST, READY, INT, LAST_CYC, HALT;
  logic [1:0] CYC_LEN;
  logic [2:0] S;
  logic       SYNC, STEP, INTACK, IRQ_PEND;
  logic [1:0] CYC;

  int n_checks = 0;
  int n_pass   = 0;

  i8008_timing_ctrl #(.CLKS_PER_STATE(CLKS), .MAX_CYC(MAXC)) dut (
    .CLK1(CLK1), .nRST(nRST), .READY(READY), .INT(INT), .CYC_LEN(CYC_LEN),
    .LAST_CYC(LAST_CYC), .HALT(HALT), .S(S), .SYNC(SYNC), .CYC(CYC),
    .STEP(STEP), .INTACK(INTACK), .IRQ_PEND(IRQ_PEND)
  );

  always #5 CLK1 = ~CLK1;

  // Reference model: phase is the clock count since reset modulo CLKS.
  int         m_ph, m_cyc, m_len;
  logic [2:0] m_s;
  bit         m_ia, m_irq;

  task automatic model_clk(input bit nrst, rdy, intr, input int len, input bit last, halt);
    bit at_step, eoc, bound, t1i;
    logic [2:0] ns;
    if (!nrst) begin
      m_ph = 0; m_s = C_STOP; m_cyc = 0; m_len = 0; m_ia = 0; m_irq = 0;
      return;
    end
    at_step = (m_ph == CLKS - 1);
    m_ph = (m_ph + 1) % CLKS;
    eoc = 0;
    ns = m_s;
    if (at_step) begin
      if (m_s == C_T1 || m_s == C_T1I) ns = C_T2;
      else if (m_s == C_T2 || m_s == C_WAIT) ns = rdy ? C_T3 : C_WAIT;
      else if (m_s == C_T3) begin
        m_len = len;
        if (m_cyc == 0 && halt) ns = C_STOP;
        else if (len == 0) eoc = 1;
        else ns = C_T4;
      end else if (m_s == C_T4) begin
        if (m_len == 1) eoc = 1; else ns = C_T5;
      end else if (m_s == C_T5) eoc = 1;
      else if (m_s == C_STOP && m_irq) begin
        ns = C_T1I; m_cyc = 0;
      end
    end
    if (eoc) begin
      bound = last || (m_cyc == MAXC - 1);
      m_cyc = bound ? 0 : m_cyc + 1;
      ns = (bound && m_irq) ? C_T1I : C_T1;
      m_ia = 0;
    end
    if (at_step && ns == C_STOP && m_s != C_STOP) m_ia = 0;
    t1i = at_step && (ns == C_T1I);
    if (t1i) m_ia = 1;
    m_irq = t1i ? 1'b0 : (m_irq | intr);
    m_s = ns;
  endtask

  function automatic logic [9:0] dut_vec();
    return {S, SYNC, CYC, STEP, INTACK, IRQ_PEND};
  endfunction

  function automatic logic [9:0] model_vec();
    logic [1:0] c;
    c = m_cyc[1:0];
    return {m_s, m_ph < CLKS / 2, c, m_ph == CLKS - 1, m_ia, m_irq};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic apply(input bit nrst, rdy, intr, input logic [1:0] len, input bit last, halt);
    nRST = nrst; READY = rdy; INT = intr; CYC_LEN = len; LAST_CYC = last; HALT = halt;
    @(posedge CLK1);
    model_clk(nrst, rdy, intr, int'(len), last, halt);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic idle();
    apply(1, 1, 0, 2'd0, 0, 0);
  endtask

  typedef struct {
    bit nrst, rdy, intr;
    logic [1:0] len;
    bit last, halt;
    logic [2:0] s;
    bit ph;
    logic [1:0] cyc;
    bit ia, irq;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input bit nrst, rdy, intr, input logic [1:0] len, input bit last, halt,
                   input logic [2:0] s, input bit ph, input logic [1:0] cyc, input bit ia, irq);
    vec_t r;
    r.nrst = nrst; r.rdy = rdy; r.intr = intr; r.len = len; r.last = last; r.halt = halt;
    r.s = s; r.ph = ph; r.cyc = cyc; r.ia = ia; r.irq = irq;
    tbl.push_back(r);
  endtask

  initial begin
    nRST = 0; READY = 1; INT = 0; CYC_LEN = 0; LAST_CYC = 0; HALT = 0;
    m_ph = 0; m_s = C_STOP; m_cyc = 0; m_len = 0; m_ia = 0; m_irq = 0;

    // reset, idle in STOPPED, INT start, 3-state cycle, WAITs, 5-state cycle with late CYC_LEN change
    v(0,1,0,0,0,0, C_STOP,0,0,0,0); v(1,1,0,0,0,0, C_STOP,1,0,0,0);
    v(1,1,0,0,0,0, C_STOP,0,0,0,0); v(1,1,1,0,0,0, C_STOP,1,0,0,1);
    v(1,1,0,0,0,0, C_T1I,0,0,1,0);  v(1,1,0,0,0,0, C_T1I,1,0,1,0);
    v(1,1,0,0,0,0, C_T2,0,0,1,0);   v(1,1,0,0,0,0, C_T2,1,0,1,0);
    v(1,1,0,0,0,0, C_T3,0,0,1,0);   v(1,1,0,0,0,0, C_T3,1,0,1,0);
    v(1,1,0,0,0,0, C_T1,0,1,0,0);   v(1,1,0,0,0,0, C_T1,1,1,0,0);
    v(1,1,0,0,0,0, C_T2,0,1,0,0);   v(1,0,0,0,0,0, C_T2,1,1,0,0);
    v(1,0,0,0,0,0, C_WAIT,0,1,0,0); v(1,0,0,0,0,0, C_WAIT,1,1,0,0);
    v(1,0,0,0,0,0, C_WAIT,0,1,0,0); v(1,0,0,0,0,0, C_WAIT,1,1,0,0);
    v(1,1,0,0,0,0, C_T3,0,1,0,0);   v(1,1,0,2,0,0, C_T3,1,1,0,0);
    v(1,1,0,2,0,1, C_T4,0,1,0,0);   v(1,1,0,0,0,0, C_T4,1,1,0,0);
    v(1,1,0,0,0,0, C_T5,0,1,0,0);   v(1,1,0,0,0,0, C_T5,1,1,0,0);
    v(1,1,0,0,1,0, C_T1,0,0,0,0);
    // INT mid-instruction, 4-state last cycle ends in T1I, then HLT
    v(1,1,1,0,0,0, C_T1,1,0,0,1);   v(1,1,0,0,0,0, C_T2,0,0,0,1);
    v(1,1,0,0,0,0, C_T2,1,0,0,1);   v(1,1,0,0,0,0, C_T3,0,0,0,1);
    v(1,1,0,0,0,0, C_T3,1,0,0,1);   v(1,1,0,1,1,0, C_T4,0,0,0,1);
    v(1,1,0,0,0,0, C_T4,1,0,0,1);   v(1,1,0,0,1,0, C_T1I,0,0,1,0);
    v(1,1,0,0,0,0, C_T1I,1,0,1,0);  v(1,1,0,0,0,0, C_T2,0,0,1,0);
    v(1,1,0,0,0,0, C_T2,1,0,1,0);   v(1,1,0,0,0,0, C_T3,0,0,1,0);
    v(1,1,0,0,0,0, C_T3,1,0,1,0);   v(1,1,0,0,0,1, C_STOP,0,0,0,0);
    v(1,1,0,0,0,0, C_STOP,1,0,0,0); v(1,1,0,0,0,0, C_STOP,0,0,0,0);

    foreach (tbl[i]) begin
      apply(tbl[i].nrst, tbl[i].rdy, tbl[i].intr, tbl[i].len, tbl[i].last, tbl[i].halt);
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].s, ~tbl[i].ph, tbl[i].cyc, tbl[i].ph, tbl[i].ia, tbl[i].irq});
    end

    // forced wrap: LAST_CYC held 0 for three 3-state cycles
    apply(0, 1, 0, 2'd0, 0, 0);
    apply(1, 1, 1, 2'd0, 0, 0);
    idle();
    chk("wrap_t1i", {S, INTACK}, {C_T1I, 1'b1});
    repeat (6) idle();
    chk("wrap_cyc1", {S, CYC, INTACK}, {C_T1, 2'd1, 1'b0});
    repeat (6) idle();
    chk("wrap_cyc2", {S, CYC}, {C_T1, 2'd2});
    repeat (6) idle();
    chk("wrap_cyc0", {S, CYC}, {C_T1, 2'd0});

    // IRQ clear wins on the T1I-entry edge, INT re-sampled next clock
    apply(0, 1, 0, 2'd0, 0, 0);
    apply(1, 1, 1, 2'd0, 0, 0);
    apply(1, 1, 1, 2'd0, 0, 0);
    chk("clr_wins", {S, IRQ_PEND}, {C_T1I, 1'b0});
    apply(1, 1, 1, 2'd0, 0, 0);
    chk("resample", IRQ_PEND, 1'b1);

    // reset during WAIT of cycle 1 with IRQ pending
    repeat (8) idle();
    apply(1, 0, 0, 2'd0, 0, 0);
    chk("in_wait", {S, CYC, IRQ_PEND}, {C_WAIT, 2'd1, 1'b1});
    apply(1, 0, 0, 2'd0, 0, 0);
    apply(0, 0, 0, 2'd0, 0, 0);
    chk("rst_wait", dut_vec(), {C_STOP, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom % 400) != 0, ($urandom % 4) != 0, ($urandom % 24) == 0,
            2'($urandom % 4), ($urandom % 2) == 1, ($urandom % 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i8008_timing_ctrl.md
Name: i8008_timing_ctrl

Overview:
- Timing and state sequencer for the 8008 core.
- Generates the processor state sequence (T1, T1I, T2, WAIT, T3, T4, T5, STOPPED) and drives the external S[2:0]/SYNC status pins.
- Tracks the machine-cycle index within an instruction and issues per-state step strobes to the datapath.
- Handles READY wait insertion, HLT stop and interrupt acceptance at instruction boundaries.
- Instantiated inside CPU; the decoder supplies cycle length and last-cycle information.

Parameters:
- CLKS_PER_STATE, 2: clock periods per processor state; even, ≥2. SYNC is high for the first half of each state, low for the second half.
- MAX_CYC, 3: maximum machine cycles per instruction.

Ports:
- CLK1 input 1: single system clock; all logic on rising edge.
- nRST input 1: synchronous active-low reset.
- READY input 1: memory/IO ready; sampled on the STEP clock of T2 and WAIT.
- INT input 1: interrupt request, level; latched.
- CYC_LEN input 2: states in current cycle, sampled on STEP of T3. 0 = end after T3; 1 = T4; 2 or 3 = T5.
- LAST_CYC input 1: current machine cycle is the last of the instruction; sampled on STEP of the cycle's final state.
- HALT input 1: HLT decoded; sampled on STEP of T3 of cycle 0.
- S output 3: state code. T1=010, T1I=011, T2=001, WAIT=000, T3=100, STOPPED=110, T4=111, T5=101.
- SYNC output 1: state-phase marker.
- CYC output 2: machine-cycle index 0..MAX_CYC-1.
- STEP output 1: high on the final clock of every state; datapath enable.
- INTACK output 1: high throughout the cycle started by T1I.
- IRQ_PEND output 1: interrupt latch value.

Behaviour:
- **Reset** (nRST=0 at clock edge): S=110 (STOPPED), SYNC=1, phase counter=0, CYC=0, STEP=0, INTACK=0, IRQ_PEND=0. Reset overrides everything, including mid-cycle and WAIT.
- **Phase counter:** counts 0..CLKS_PER_STATE-1 and wraps.
  - SYNC=1 while count < CLKS_PER_STATE/2.
  - STEP=1 when count = CLKS_PER_STATE-1.
  - State changes only on the clock edge where STEP=1. The counter runs in every state, including WAIT and STOPPED.
- **IRQ latch:** set when INT=1 on any clock. Cleared on the STEP that enters T1I. Set and clear on the same edge: clear wins, and INT is re-sampled next clock.
- **Transitions** (evaluated on STEP):
  - T1 or T1I -> T2.
  - T2: READY=1 -> T3; READY=0 -> WAIT.
  - WAIT: READY=1 -> T3; otherwise stay in WAIT.
  - T3:
    - CYC=0 and HALT=1 -> STOPPED.
    - Else CYC_LEN=0 -> end of cycle.
    - Else -> T4.
  - T4: CYC_LEN(latched at T3)=1 -> end of cycle; else -> T5.
  - T5 -> end of cycle.
  - STOPPED: IRQ_PEND=1 -> T1I with CYC=0; else stay in STOPPED.
- **End of cycle:**
  - If LAST_CYC=1 or CYC=MAX_CYC-1 (forced boundary): CYC<=0, next state T1I if IRQ_PEND else T1.
  - Otherwise: CYC<=CYC+1, next state T1.
- **INTACK:** set on entry to T1I; cleared on the next end-of-cycle or on entry to STOPPED.
- CYC_LEN latched at T3 STEP; later changes are ignored within the cycle.
- HALT in cycles other than 0 is ignored.
- Sequence latency: one state = CLKS_PER_STATE clocks. A 3-state cycle takes 3*CLKS_PER_STATE clocks, plus CLKS_PER_STATE per WAIT state.

Test Plan:
- **Reset, then start:** reset, hold INT=0 for 20 clocks -> S stays 110, SYNC toggles 1,0 every clock, STEP every 2nd clock. Pulse INT for 1 clock -> IRQ_PEND=1, next S=011, then 001, INTACK=1, IRQ_PEND=0.
- **3-state, 3-cycle instruction:** CYC_LEN=0, READY=1, LAST_CYC=0,0,1 -> S repeats 010,001,100 with CYC 0,1,2, then returns to 010 with CYC=0; 18 clocks total.
- **Wait insertion:** READY=0 for 3 states from T2 -> S 001,000,000,000,100. SYNC keeps toggling; CYC unchanged.
- **5-state cycle:** CYC_LEN=2, LAST_CYC=1 -> S 010,001,100,111,101,010. Changing CYC_LEN after T3 has no effect.
- **Interrupt and halt:**
  - INT during cycle 1 of a 2-cycle instruction -> next state after the last state is 011, not 010.
  - HALT=1 at T3 of cycle 0 -> S=110; remains there until INT, then 011.
  - LAST_CYC held 0 for 3 cycles -> forced wrap to CYC=0 after cycle 2.
- **Reset mid-operation:** assert nRST=0 during WAIT with IRQ_PEND=1 -> next clock S=110, CYC=0, INTACK=0, IRQ_PEND=0, SYNC=1.
